// File: rtl/multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multiplier_pkg
// Brief    : Shared arithmetics package. Holds the state encoding used by the
//            sequential arithmetic units (multiplier, divider).
// Revision : 1.0 - initial release
// ============================================================================
package multiplier_pkg;

    // Handshake states common to the sequential arithmetic units
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULT     = 2'd1,
        FINISHED = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// ============================================================================
// Module   : adder
// Brief    : Combinational WIDTH-bit adder with carry-in. The carry-out is
//            discarded; callers size WIDTH so that it can never be needed.
// Revision : 1.0 - initial release
// ============================================================================
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [WIDTH-1:0] out_sum
);

    // Plain sum; bits above WIDTH are dropped
    assign out_sum = in_a + in_b + WIDTH'(in_cin);

endmodule
`default_nettype wire

// File: rtl/multiplier.sv
`default_nettype none
// ============================================================================
// Module   : multiplier
// Brief    : Sequential unsigned shift-and-add multiplier, BITS x BITS ->
//            2*BITS. One partial-product step per clock, fixed latency of
//            BITS cycles, start/finished handshake shared with divider.
// Revision : 1.0 - initial release
// ============================================================================
module multiplier
    import multiplier_pkg::*;
#(
    parameter int BITS = 16
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic [BITS-1:0]   in_a,
    input  logic [BITS-1:0]   in_b,
    input  logic              in_start,
    output logic              out_finished,
    output logic [2*BITS-1:0] out_prod
);

    // Counter width; kept at least one bit so BITS=1 still elaborates
    localparam int CNT_W = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(BITS - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic                w_load;
    logic [2*BITS-1:0]   r_a_sh;
    logic [BITS-1:0]     r_b_sh;
    logic [2*BITS-1:0]   r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*BITS-1:0]   r_prod;
    logic [2*BITS-1:0]   w_sum;
    logic [2*BITS-1:0]   w_acc_next;

    // Accumulate the shifted multiplicand; accumulator is wide enough that
    // the carry-out is never meaningful
    adder #(
        .WIDTH (2*BITS)
    ) u_adder (
        .in_a    (r_acc),
        .in_b    (r_a_sh),
        .in_cin  (1'b0),
        .out_sum (w_sum)
    );

    assign w_acc_next   = r_b_sh[0] ? w_sum : r_acc;
    assign out_finished = (r_state == FINISHED);
    assign out_prod     = r_prod;

    // State register
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; w_load marks edges that latch fresh operands
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE, FINISHED: begin
                if (in_start) begin
                    w_state_next = MULT;
                    w_load       = 1'b1;
                end
            end
            MULT: begin
                if (r_cnt == c_last) begin
                    w_state_next = FINISHED;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand latch, one shift-and-add step per MULT cycle, and
    // result capture only on the final step so partial sums never escape
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_prod <= '0;
        end else if (w_load) begin
            r_a_sh <= {{BITS{1'b0}}, in_a};
            r_b_sh <= in_b;
            r_acc  <= '0;
            r_cnt  <= '0;
        end else if (r_state == MULT) begin
            r_acc  <= w_acc_next;
            r_a_sh <= r_a_sh << 1;
            r_b_sh <= r_b_sh >> 1;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (r_cnt == c_last) begin
                r_prod <= w_acc_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiplier
// Brief    : Directed self-checking bench for multiplier (BITS=16): latency,
//            products, restart from FINISHED, ignored inputs in MULT,
//            mid-operation reset and back-to-back operation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiplier;

    localparam int BITS = 16;

    logic              clk;
    logic              rst;
    logic [BITS-1:0]   a;
    logic [BITS-1:0]   b;
    logic              start;
    logic              finished;
    logic [2*BITS-1:0] prod;

    int total = 0;
    int bad   = 0;

    multiplier #(
        .BITS (BITS)
    ) u_dut (
        .in_clk       (clk),
        .in_rst       (rst),
        .in_a         (a),
        .in_b         (b),
        .in_start     (start),
        .out_finished (finished),
        .out_prod     (prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle at the falling edge for sampling/driving
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start one operation and follow it edge by edge to completion.
    // old_prod is the result that must stay visible until completion.
    // disturb: change operands and pulse start during MULT.
    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic [31:0] old_prod, input logic [31:0] exp_prod,
                          input bit disturb);
        a     = va;
        b     = vb;
        start = 1'b1;
        step();                       // edge 1
        start = 1'b0;
        check({tag, "_fin_e1"}, {31'd0, finished}, 32'd0);
        check({tag, "_hold_e1"}, prod, old_prod);
        for (int i = 2; i <= 16; i++) begin
            if (disturb && i == 4) begin
                a     = 16'd999;
                b     = 16'd777;
                start = 1'b1;
            end
            step();
            start = 1'b0;
            check({tag, "_fin_wait"}, {31'd0, finished}, 32'd0);
            check({tag, "_hold_wait"}, prod, old_prod);
        end
        step();                       // edge 17
        check({tag, "_fin_e17"}, {31'd0, finished}, 32'd1);
        check({tag, "_prod"}, prod, exp_prod);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        a     = 16'd0;
        b     = 16'd0;
        @(negedge clk);
        step();
        check("rst_fin", {31'd0, finished}, 32'd0);
        check("rst_prod", prod, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        step();
        check("idle_fin", {31'd0, finished}, 32'd0);

        run_op("m500x123", 16'd500, 16'd123, 32'd0, 32'h0000F03C, 1'b0);

        // FINISHED holds while start is low
        for (int i = 0; i < 3; i++) begin
            step();
            check("fin_hold", {31'd0, finished}, 32'd1);
            check("fin_prod_hold", prod, 32'd61500);
        end

        run_op("m7x9", 16'd7, 16'd9, 32'd61500, 32'd63, 1'b0);
        run_op("mffff", 16'hFFFF, 16'hFFFF, 32'd63, 32'hFFFE0001, 1'b0);
        run_op("m0x1234", 16'd0, 16'd1234, 32'hFFFE0001, 32'd0, 1'b0);
        run_op("m4321x0", 16'd4321, 16'd0, 32'd0, 32'd0, 1'b0);
        run_op("ignore", 16'd10, 16'd20, 32'd0, 32'd200, 1'b1);

        // Reset during the 5th MULT cycle aborts the operation
        a     = 16'd11;
        b     = 16'd13;
        start = 1'b1;
        step();                       // edge 1 -> MULT
        start = 1'b0;
        for (int i = 2; i <= 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_fin", {31'd0, finished}, 32'd0);
        check("abort_prod", prod, 32'd0);
        step();
        check("abort_idle", {31'd0, finished}, 32'd0);
        check("abort_idle_prod", prod, 32'd0);

        run_op("m3x5", 16'd3, 16'd5, 32'd0, 32'd15, 1'b0);

        // start held high: one-cycle finished pulse every 17 cycles
        a     = 16'd2;
        b     = 16'd3;
        start = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int j = 1; j <= 16; j++) begin
                step();
                check("b2b_fin_low", {31'd0, finished}, 32'd0);
            end
            step();
            check("b2b_fin_pulse", {31'd0, finished}, 32'd1);
            check("b2b_prod", prod, 32'd6);
        end
        step();
        check("b2b_fin_drop", {31'd0, finished}, 32'd0);
        check("b2b_prod_keep", prod, 32'd6);
        start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
